// File: rtl/systolic_feeder.sv
// systolic_feeder
//
// Transmit side of the PE operand interface for an N x N systolic array.
// Holds one N x N A tile and one N x N B tile, loaded through a write port
// while idle. On start it pulses the array clear, streams the diagonally
// skewed operands on the west (a_row) and north (b_col) edges, flushes
// with zeros so the last operands reach PE(N-1,N-1), then pulses done.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   wr_en    operand write strobe (honoured only while idle)
//   wr_sel   write target: 0 = A tile, 1 = B tile
//   wr_row   row index of the write
//   wr_col   column index of the write
//   wr_data  operand value
//   start    single-cycle run request (sampled only while idle)
//   a_row    west-edge operands, row i on a_row[i*DW +: DW]
//   b_col    north-edge operands, column j on b_col[j*DW +: DW]
//   clear    accumulator clear to all PEs
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse: array results are final
//
// Handshake: start is a single-cycle request with no acknowledge; it is
// taken only when busy=0 and dropped otherwise. done is a one-cycle pulse
// with no back-pressure. All outputs come straight from flops.

module systolic_feeder #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_row,
  input  logic [AW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic [N*DW-1:0] a_row,
  output logic [N*DW-1:0] b_col,
  output logic            clear,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [N*DW-1:0] a_nx;
  logic [N*DW-1:0] b_nx;
  logic            wr_ok;

  logic [DW-1:0] a_mem [N][N];
  logic [DW-1:0] b_mem [N][N];

  // Out-of-range indices can only occur when N is not a power of two.
  assign wr_ok = (state == S_IDLE) && wr_en &&
                 (int'(wr_row) < N) && (int'(wr_col) < N);

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_FEED;
      S_FEED: begin
        if (cnt == FEED_LAST) state_nx = S_FLUSH;
        else                  cnt_nx   = cnt + 1'b1;
      end
      S_FLUSH: begin
        if (cnt == FLUSH_LAST) state_nx = S_DONE;
        else                   cnt_nx   = cnt + 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands are selected from the next state/counter so the registered
  // outputs line up with the state they belong to. Element [i][k] appears
  // at feed step t = i + k: A[i][k] on row i, B[i][k] on column k.
  always_comb begin
    a_nx = '0;
    b_nx = '0;
    if (state_nx == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cnt_nx == CW'(i + k)) begin
            a_nx[i*DW +: DW] = a_mem[i][k];
            b_nx[k*DW +: DW] = b_mem[i][k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_row <= '0;
      b_col <= '0;
      clear <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      a_row <= a_nx;
      b_col <= b_nx;
      clear <= (state_nx == S_CLEAR);
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
    end
  end

  // A write in the same idle cycle as start lands before FEED reads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          a_mem[i][k] <= '0;
          b_mem[i][k] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

endmodule
